move_path_player: RTL and testbench
===================================

// Module: move_path_player
// PURPOSE
//   Downstream consumer of the maze solver's move stream. Records each rat step on a move stack,
//   popping on backtrack steps, so the stack always holds the current start-to-position path.
//   On done it replays the final path, oldest move first, over a valid/ready handshake to a
//   display or UART stage. On fail it stops recording and holds an error.
// PARAMETERS
//   DEPTH  256  max recorded path length in moves (16x16 maze); stack entries are 2 bits
//   AW     8    address width, clog2(DEPTH); count port is AW+1 bits
// PORTS
//   clk        in   1     system clock, all state on rising edge
//   rst        in   1     asynchronous reset, active-low (0 = reset)
//   start      in   1     begin or restart a recording session (same pulse that starts the solver)
//   move_vld   in   1     one-cycle strobe: move is a valid solver step this cycle
//   move_back  in   1     qualifies move_vld: 1 = backtrack step (pop), 0 = forward step (push)
//   move       in   2     step direction from solver (00 R, 01 U, 10 L, 11 D)
//   done       in   1     solver reached goal
//   fail       in   1     solver found no path
//   out_ready  in   1     downstream accepts out_move this cycle
//   out_valid  out  1     out_move/out_last valid
//   out_move   out  2     replayed move
//   out_last   out  1     out_move is final path entry
//   count      out  AW+1  current stack depth
//   busy       out  1     state is RECORD or PLAY
//   play_done  out  1     replay finished; held until start
//   error      out  1     fail seen or stack overflow; held until start
// BEHAVIOUR
//   Reset: state IDLE; sp=0, rd_ptr=0; every output 0. Stack contents undefined, never read
//     beyond sp.
//   States: IDLE, RECORD, PLAY, FIN, ERR. All transitions registered, one cycle each.
//   IDLE: start -> RECORD with sp=0. All other inputs ignored.
//   RECORD (busy=1), per-cycle priority:
//     1. start: sp<=0, stay RECORD. A move_vld in the same cycle is dropped.
//     2. move_vld & !move_back & sp<DEPTH: mem[sp]<=move, sp<=sp+1.
//        move_vld & !move_back & sp==DEPTH: no write, error<=1 -> ERR.
//     3. move_vld & move_back: sp<=sp-1 if sp>0; ignored at sp==0 (no wrap).
//     4. fail -> ERR, error<=1. Same-cycle move_vld is still applied first.
//        done -> PLAY with rd_ptr<=0; same-cycle move_vld applied first.
//        If the resulting sp==0 -> FIN instead.
//        done and fail together: fail wins.
//   PLAY (busy=1): out_valid=1 from the first cycle in PLAY; out_move=mem[rd_ptr];
//     out_last=(rd_ptr==sp-1).
//     - Transfer when out_valid&out_ready: rd_ptr<=rd_ptr+1. Transfer with out_last -> FIN,
//       out_valid<=0.
//     - out_move/out_last stay stable while out_valid&!out_ready.
//     - start, move_vld, done, fail ignored. sp unchanged.
//   FIN: play_done=1, out_valid=0. start -> RECORD, sp<=0, play_done<=0.
//   ERR: error=1. start -> RECORD, sp<=0, error<=0. Nothing replayed.
//   count=sp in every state; updates the cycle after the push/pop.
//   Async reset mid-RECORD/PLAY returns to IDLE immediately; any partial replay is abandoned.
// TESTING
//   1. start; push R,R,D,D; done; out_ready=1 -> out_move R,R,D,D on 4 consecutive cycles,
//      out_last on 4th; play_done=1, count=4.
//   2. start; push R,U; back-step U; push L; done -> replay R,L only, count=2.
//   3. Replay with out_ready toggling 1,0,0,1 -> each move held stable while stalled;
//      no loss or duplication.
//   4. Push DEPTH moves, then one more -> error=1, state ERR, count=DEPTH; start clears
//      error, count=0.
//   5. Back-step at sp=0 -> count stays 0. done with empty stack -> play_done=1 next cycle,
//      out_valid never 1.
//   6. fail after 3 pushes -> error=1, no out_valid. rst=0 mid-PLAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/move_path_player.sv
// Move-stack recorder for the maze solver: pushes forward steps, pops backtracks,
// and replays the surviving start-to-goal path oldest-first over valid/ready.
module move_path_player #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          move_vld,
  input  logic          move_back,
  input  logic [1:0]    move,
  input  logic          done,
  input  logic          fail,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [1:0]    out_move,
  output logic          out_last,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          play_done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY,
    S_FIN,
    S_ERR
  } state_t;

  localparam logic [AW:0] SP_ONE   = (AW+1)'(1);
  localparam logic [AW:0] SP_DEPTH = (AW+1)'(DEPTH);

  state_t      r_state, w_state_nxt;
  logic [AW:0] r_sp, w_sp_nxt;
  logic [AW:0] r_rd_ptr, w_rd_nxt;
  logic [AW:0] w_sp_after;
  logic        w_push;
  logic        w_overflow;
  logic        w_xfer;
  logic [1:0]  r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_sp     <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sp     <= w_sp_nxt;
      r_rd_ptr <= w_rd_nxt;
    end
  end

  // NOTE: the stack storage has no reset; it is only read below sp, so it never needs one.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_sp[AW-1:0]] <= move;
  end

  assign w_xfer = (r_state == S_PLAY) && out_ready;

  // NOTE: every comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    w_sp_nxt    = r_sp;
    w_rd_nxt    = r_rd_ptr;
    w_sp_after  = r_sp;
    w_push      = 1'b0;
    w_overflow  = 1'b0;

    unique case (r_state)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) begin
          w_state_nxt = S_RECORD;
          w_sp_nxt    = '0;
        end
      end

      S_RECORD: begin
        if (start) begin
          w_sp_nxt = '0;
        end else begin
          // Step first, then let fail/done decide where the resulting stack goes.
          if (move_vld && !move_back) begin
            if (r_sp < SP_DEPTH) begin
              w_push     = 1'b1;
              w_sp_after = r_sp + SP_ONE;
            end else begin
              w_overflow = 1'b1;
            end
          end else if (move_vld && move_back && (r_sp != '0)) begin
            w_sp_after = r_sp - SP_ONE;
          end
          w_sp_nxt = w_sp_after;

          if (w_overflow || fail) begin
            w_state_nxt = S_ERR;
          end else if (done) begin
            w_rd_nxt    = '0;
            w_state_nxt = (w_sp_after == '0) ? S_FIN : S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (w_xfer) begin
          w_rd_nxt = r_rd_ptr + SP_ONE;
          if (out_last) w_state_nxt = S_FIN;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_valid = (r_state == S_PLAY);
  assign out_move  = out_valid ? r_mem[r_rd_ptr[AW-1:0]] : 2'b00;
  assign out_last  = out_valid && (r_rd_ptr == (r_sp - SP_ONE));
  assign count     = r_sp;
  assign busy      = (r_state == S_RECORD) || (r_state == S_PLAY);
  assign play_done = (r_state == S_FIN);
  assign error     = (r_state == S_ERR);

endmodule

// File: tb/tb_move_path_player.sv
// Directed bench for move_path_player: stimulus queues expected replay entries,
// an independent negedge monitor checks every presented output against them.
module tb_move_path_player;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          move_vld = 1'b0;
  logic          move_back = 1'b0;
  logic [1:0]    move = 2'b00;
  logic          done = 1'b0;
  logic          fail = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [1:0]    out_move;
  logic          out_last;
  logic [AW:0]   count;
  logic          busy;
  logic          play_done;
  logic          error;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entries are {move, last}.
  logic [2:0] sb[$];

  always #5 clk = ~clk;

  move_path_player #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .move_vld(move_vld),
    .move_back(move_back), .move(move), .done(done), .fail(fail),
    .out_ready(out_ready), .out_valid(out_valid), .out_move(out_move),
    .out_last(out_last), .count(count), .busy(busy),
    .play_done(play_done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Any presented beat must match the scoreboard head; it is consumed on transfer.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_move", 32'(out_move), 32'(sb[0][2:1]));
        check("out_last", 32'(out_last), 32'(sb[0][0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push(input logic [1:0] m);
    move_vld = 1'b1; move_back = 1'b0; move = m;
    tick();
    move_vld = 1'b0;
  endtask

  task automatic back_step();
    move_vld = 1'b1; move_back = 1'b1;
    tick();
    move_vld = 1'b0; move_back = 1'b0;
  endtask

  task automatic do_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic wait_play_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (play_done) break;
    end
  endtask

  int ncyc;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_play_done", 32'(play_done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b1;
    tick();

    // 1: R,R,D,D replayed back-to-back
    out_ready = 1'b1;
    do_start();
    check("t1_busy", 32'(busy), 32'd1);
    push(2'b00); push(2'b00); push(2'b11); push(2'b11);
    check("t1_count_rec", 32'(count), 32'd4);
    sb.push_back({2'b00, 1'b0});
    sb.push_back({2'b00, 1'b0});
    sb.push_back({2'b11, 1'b0});
    sb.push_back({2'b11, 1'b1});
    do_done();
    wait_play_done(20, ncyc);
    check("t1_cycles", 32'(ncyc), 32'd5);
    check("t1_play_done", 32'(play_done), 32'd1);
    check("t1_count", 32'(count), 32'd4);
    check("t1_drained", 32'(sb.size()), 32'd0);

    // 2: backtrack removes U, replay R,L
    tick();
    do_start();
    check("t2_restart_done", 32'(play_done), 32'd0);
    push(2'b00); push(2'b01);
    back_step();
    check("t2_count_pop", 32'(count), 32'd1);
    push(2'b10);
    sb.push_back({2'b00, 1'b0});
    sb.push_back({2'b10, 1'b1});
    do_done();
    wait_play_done(20, ncyc);
    check("t2_play_done", 32'(play_done), 32'd1);
    check("t2_count", 32'(count), 32'd2);
    check("t2_drained", 32'(sb.size()), 32'd0);

    // 3: ready pattern 1,0,0,1 stalls the second move
    tick();
    do_start();
    push(2'b00); push(2'b01); push(2'b10);
    sb.push_back({2'b00, 1'b0});
    sb.push_back({2'b01, 1'b0});
    sb.push_back({2'b10, 1'b1});
    do_done();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b1; tick();
    check("t3_play_done", 32'(play_done), 32'd1);
    check("t3_drained", 32'(sb.size()), 32'd0);

    // 4: overflow after DEPTH pushes
    do_start();
    for (int i = 0; i < DEPTH; i++) push(2'(i));
    check("t4_count_full", 32'(count), 32'(DEPTH));
    check("t4_no_error", 32'(error), 32'd0);
    push(2'b01);
    check("t4_error", 32'(error), 32'd1);
    check("t4_count_ovf", 32'(count), 32'(DEPTH));
    check("t4_busy", 32'(busy), 32'd0);
    do_start();
    check("t4_error_clr", 32'(error), 32'd0);
    check("t4_count_clr", 32'(count), 32'd0);

    // 5: back-step on empty stack, then done with nothing recorded
    back_step();
    check("t5_count_nowrap", 32'(count), 32'd0);
    do_done();
    check("t5_play_done", 32'(play_done), 32'd1);
    check("t5_no_valid", 32'(out_valid), 32'd0);

    // 6: fail after 3 pushes, then reset in the middle of a replay
    do_start();
    push(2'b11); push(2'b10); push(2'b01);
    fail = 1'b1; tick(); fail = 1'b0;
    check("t6_error", 32'(error), 32'd1);
    check("t6_count", 32'(count), 32'd3);
    check("t6_no_valid", 32'(out_valid), 32'd0);
    do_start();
    push(2'b00); push(2'b01); push(2'b10);
    out_ready = 1'b0;
    sb.push_back({2'b00, 1'b0});
    sb.push_back({2'b01, 1'b0});
    sb.push_back({2'b10, 1'b1});
    do_done();
    tick();
    check("t6_in_play", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    sb.delete();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_move", 32'(out_move), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(play_done), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
